// File: rtl/rtc_write_channel.sv
// Write channel of the CAN controller microcontroller interface: captures a host write,
// validates the address and drives a one-hot register strobe until ack or timeout.
module rtc_write_channel #(
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [30:0] WR_MASK     = 31'h7FFF_FFF3
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wr_en,
  input  logic [5:0]  i_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_ack,
  output logic [30:0] wr_dec_addr,
  output logic [31:0] o_reg_w_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [30:0]       r_dec;
  logic [31:0]       r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [30:0]       w_dec;
  logic              w_valid;
  logic              w_cnt_last;

  // Register map has a hole: 0x09-0x13 are unmapped, 0x14-0x20 land on bits 18-30.
  function automatic logic [30:0] decode(input logic [5:0] a);
    logic [30:0] v;
    v = '0;
    if (a <= 6'd8)
      v = 31'd1 << a;
    else if ((a >= 6'd20) && (a <= 6'd32))
      v = 31'd1 << (a - 6'd2);
    return v;
  endfunction

  assign w_dec      = decode(i_addr);
  assign w_valid    = |(w_dec & WR_MASK);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_dec   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && i_wr_en) begin
        r_dec  <= w_dec;
        r_data <= i_wr_data;
      end
      // Counter is held at zero in IDLE so every WRITE starts from a clean count.
      if (r_state == ST_IDLE)
        r_cnt <= '0;
      else if ((r_state == ST_WRITE) && !i_ack && !w_cnt_last)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    wr_dec_addr  = '0;
    o_reg_w_data = '0;
    o_busy       = (r_state != ST_IDLE);
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_wr_en)
          w_state_nxt = w_valid ? ST_WRITE : ST_ERR;
      end
      ST_WRITE: begin
        wr_dec_addr  = r_dec;
        o_reg_w_data = r_data;
        if (i_ack)
          w_state_nxt = ST_DONE;
        else if (w_cnt_last)
          w_state_nxt = ST_ERR;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        o_err       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rtc_write_channel.sv
// Self-checking bench for rtc_write_channel: transaction-level reference model with
// randomized addresses, data and ack timing.
module tb_rtc_write_channel;

  localparam int          TO      = 16;
  localparam logic [30:0] MASK_TB = 31'h7FFF_FFF3;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_wr_en;
  logic [5:0]  i_addr;
  logic [31:0] i_wr_data;
  logic        i_ack;
  logic [30:0] wr_dec_addr;
  logic [31:0] o_reg_w_data;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int n_tests = 0;
  int n_fail  = 0;
  int map_bit [64];

  rtc_write_channel #(.TIMEOUT_CYC(TO), .WR_MASK(MASK_TB)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr_en(i_wr_en), .i_addr(i_addr),
    .i_wr_data(i_wr_data), .i_ack(i_ack), .wr_dec_addr(wr_dec_addr),
    .o_reg_w_data(o_reg_w_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [30:0] exp_onehot(input int a);
    logic [30:0] v;
    v = '0;
    if (map_bit[a] >= 0) v[map_bit[a]] = 1'b1;
    return v;
  endfunction

  function automatic bit exp_valid(input int a);
    return (map_bit[a] >= 0) && MASK_TB[map_bit[a]];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_strb"}, {1'b0, wr_dec_addr}, 32'd0);
    check({tag, "_data"}, o_reg_w_data, 32'd0);
  endtask

  // One full transaction. ack_at = strobe cycle (1-based) in which ack is raised, 0 = never.
  task automatic run_txn(input int a, input logic [31:0] d, input int ack_at, input bit scramble);
    logic [30:0] oh;
    bit          acked;
    int          cyc;
    oh    = exp_onehot(a);
    acked = 1'b0;
    i_wr_en   = 1'b1;
    i_addr    = 6'(a);
    i_wr_data = d;
    i_ack     = 1'b0;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0;
    if (exp_valid(a)) begin
      cyc = 1;
      forever begin
        check("strb", {1'b0, wr_dec_addr}, {1'b0, oh});
        check("wdata", o_reg_w_data, d);
        check("busy_w", 32'(o_busy), 32'd1);
        check("pulse_w", {30'd0, o_done, o_err}, 32'd0);
        i_ack = (cyc == ack_at);
        if (scramble) begin
          i_addr    = 6'($urandom_range(63));
          i_wr_data = $urandom;
          i_wr_en   = 1'($urandom_range(1));
        end
        @(posedge i_clk); #1;
        if (cyc == ack_at) begin acked = 1'b1; break; end
        if (cyc == TO) break;
        cyc++;
      end
      i_ack   = 1'b0;
      i_wr_en = 1'b0;
      check("done", 32'(o_done), 32'(acked));
      check("err_to", 32'(o_err), 32'(!acked));
    end else begin
      check("err_inv", 32'(o_err), 32'd1);
      check("done_inv", 32'(o_done), 32'd0);
    end
    check("strb_end", {1'b0, wr_dec_addr}, 32'd0);
    check("busy_end", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    check_idle("back_idle");
    check("pulse_idle", {30'd0, o_done, o_err}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) map_bit[i] = -1;
    for (int i = 0; i <= 8; i++) map_bit[i] = i;
    for (int i = 20; i <= 32; i++) map_bit[i] = i - 2;

    // Reset with random inputs
    i_reset_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_wr_en   = 1'($urandom_range(1));
      i_addr    = 6'($urandom_range(63));
      i_wr_data = $urandom;
      i_ack     = 1'($urandom_range(1));
      @(posedge i_clk); #1;
      check_idle("rst");
      check("rst_pulse", {30'd0, o_done, o_err}, 32'd0);
    end
    i_wr_en = 1'b0; i_ack = 1'b0;
    #2 i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    check_idle("post_rst");

    // Directed valid write, ack raised in the 3rd strobe cycle
    run_txn(8'h14, 32'hDEAD_BEEF, 3, 1'b0);

    // Map sweep with immediate ack
    for (int a = 0; a < 64; a++) run_txn(a, $urandom, 1, 1'b0);

    // Timeout, then ack exactly on the limit cycle
    run_txn(32, 32'h1234_5678, 0, 1'b0);
    run_txn(32, 32'h8765_4321, TO, 1'b0);

    // Input scrambling during WRITE
    run_txn(5, 32'hCAFE_F00D, 6, 1'b1);

    // Stray ack in IDLE
    i_ack = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
      check_idle("stray_ack");
      check("stray_pulse", {30'd0, o_done, o_err}, 32'd0);
    end
    i_ack = 1'b0;

    // Randomized transactions
    for (int n = 0; n < 40; n++)
      run_txn(int'($urandom_range(63)), $urandom, int'($urandom_range(TO + 2)), 1'($urandom_range(1)));

    // Back-to-back: wr_en held for 10 edges, ack held high; period is W, D, I
    i_addr = 6'd0; i_wr_data = 32'h0BAD_CAFE; i_ack = 1'b1; i_wr_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge i_clk); #1;
      if (k == 10) i_wr_en = 1'b0;
      check("b2b_busy", 32'(o_busy), 32'((k % 3) != 0));
      check("b2b_strb", {1'b0, wr_dec_addr}, ((k % 3) == 1) ? 32'd1 : 32'd0);
      check("b2b_done", 32'(o_done), 32'((k % 3) == 2));
      check("b2b_err", 32'(o_err), 32'd0);
    end
    i_ack = 1'b0;

    // Reset asserted in the middle of a WRITE
    i_wr_en = 1'b1; i_addr = 6'd5; i_wr_data = 32'h5555_AAAA;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0;
    check("mid_strb_up", {1'b0, wr_dec_addr}, 32'h20);
    #2 i_reset_n = 1'b0;
    #1;
    check_idle("mid_rst_async");
    check("mid_rst_pulse", {30'd0, o_done, o_err}, 32'd0);
    @(posedge i_clk); #1;
    check("mid_rst_hold", {30'd0, o_done, o_err}, 32'd0);
    #2 i_reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clk); #1;
      check_idle("mid_rst_rel");
      check("mid_rst_rel_pulse", {30'd0, o_done, o_err}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
